// File: rtl/cr_kme_fifo_param.sv
// Parameterised first-word-fall-through FIFO with advisory stall threshold,
// registered occupancy and one-cycle overflow/underflow pulses.
module cr_kme_fifo_param #(
  parameter int DATA_WIDTH   = 128,
  parameter int DEPTH        = 4,
  parameter int STALL_THRESH = 0,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_in,
  input  logic                  fifo_in_valid,
  input  logic                  fifo_in_stall_override,
  input  logic                  clear,
  input  logic                  fifo_out_ack,
  output logic                  fifo_in_stall,
  output logic [DATA_WIDTH-1:0] fifo_out,
  output logic                  fifo_out_valid,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow,
  output logic [CW-1:0]         used_slots,
  output logic [CW-1:0]         free_slots
);
  localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   THR_C   = CW'(STALL_THRESH);
  localparam logic [PW-1:0]   LAST    = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  full, ren, wen;

  assign fifo_out_valid = (used_slots != '0);
  assign full           = (used_slots == DEPTH_C);
  assign ren            = fifo_out_valid & fifo_out_ack;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wen            = fifo_in_valid & (~full | ren);
  assign fifo_out       = mem[rd_ptr];
  assign fifo_in_stall  = (free_slots <= THR_C) & ~fifo_in_stall_override;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      used_slots     <= '0;
      free_slots     <= DEPTH_C;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      used_slots     <= '0;
      free_slots     <= DEPTH_C;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      fifo_overflow  <= fifo_in_valid & ~wen;
      fifo_underflow <= fifo_out_ack & ~fifo_out_valid;
      if (wen) wr_ptr <= nxt(wr_ptr);
      if (ren) rd_ptr <= nxt(rd_ptr);
      if (wen && !ren) begin
        used_slots <= used_slots + CW'(1);
        free_slots <= free_slots - CW'(1);
      end else if (ren && !wen) begin
        used_slots <= used_slots - CW'(1);
        free_slots <= free_slots + CW'(1);
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wen && !clear) mem[wr_ptr] <= fifo_in;
  end

endmodule

// File: tb/tb_cr_kme_fifo_param.sv
// Bench for cr_kme_fifo_param: DEPTH=4/THRESH=0 and DEPTH=5/THRESH=2 instances
// checked every cycle against a queue model plus directed literal checks.
module tb_cr_kme_fifo_param;
  localparam int DW = 16;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] din  [2];
  logic          vld  [2];
  logic          ovr  [2];
  logic          clr  [2];
  logic          ack  [2];
  logic          stall[2];
  logic [DW-1:0] dout [2];
  logic          ovld [2];
  logic          ovf  [2];
  logic          udf  [2];
  logic [CW-1:0] used [2];
  logic [CW-1:0] free [2];

  int errors = 0;
  int checks = 0;

  cr_kme_fifo_param #(.DATA_WIDTH(DW), .DEPTH(4), .STALL_THRESH(0)) u_a (
    .clk(clk), .rst_n(rst_n), .fifo_in(din[0]), .fifo_in_valid(vld[0]),
    .fifo_in_stall_override(ovr[0]), .clear(clr[0]), .fifo_out_ack(ack[0]),
    .fifo_in_stall(stall[0]), .fifo_out(dout[0]), .fifo_out_valid(ovld[0]),
    .fifo_overflow(ovf[0]), .fifo_underflow(udf[0]),
    .used_slots(used[0]), .free_slots(free[0]));

  cr_kme_fifo_param #(.DATA_WIDTH(DW), .DEPTH(5), .STALL_THRESH(2)) u_b (
    .clk(clk), .rst_n(rst_n), .fifo_in(din[1]), .fifo_in_valid(vld[1]),
    .fifo_in_stall_override(ovr[1]), .clear(clr[1]), .fifo_out_ack(ack[1]),
    .fifo_in_stall(stall[1]), .fifo_out(dout[1]), .fifo_out_valid(ovld[1]),
    .fifo_overflow(ovf[1]), .fifo_underflow(udf[1]),
    .used_slots(used[1]), .free_slots(free[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue-level reference model of both instances.
  typedef logic [DW-1:0] q_t [$];
  q_t   mq [2];
  int   dep [2] = '{4, 5};
  int   thr [2] = '{0, 2};
  logic m_ovf [2];
  logic m_udf [2];

  always @(posedge clk or negedge rst_n) begin
    int  n;
    bit  r, w;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        m_ovf[k] <= 1'b0;
        m_udf[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (clr[k]) begin
          mq[k].delete();
          m_ovf[k] <= 1'b0;
          m_udf[k] <= 1'b0;
        end else begin
          n = mq[k].size();
          r = ack[k] && (n != 0);
          w = vld[k] && ((n < dep[k]) || r);
          m_ovf[k] <= vld[k] && !w;
          m_udf[k] <= ack[k] && (n == 0);
          if (r) void'(mq[k].pop_front());
          if (w) mq[k].push_back(din[k]);
        end
      end
    end
  end

  always @(negedge clk) begin
    int n;
    for (int k = 0; k < 2; k++) begin
      n = mq[k].size();
      chk($sformatf("m_used%0d", k),  32'(used[k]), 32'(n));
      chk($sformatf("m_free%0d", k),  32'(free[k]), 32'(dep[k] - n));
      chk($sformatf("m_valid%0d", k), 32'(ovld[k]), 32'(n != 0));
      chk($sformatf("m_ovf%0d", k),   32'(ovf[k]),  32'(m_ovf[k]));
      chk($sformatf("m_udf%0d", k),   32'(udf[k]),  32'(m_udf[k]));
      chk($sformatf("m_stall%0d", k), 32'(stall[k]),
          32'(((dep[k] - n) <= thr[k]) && !ovr[k]));
      if (n != 0) chk($sformatf("m_head%0d", k), 32'(dout[k]), 32'(mq[k][0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [DW-1:0] v);
    din[k] = v;
    vld[k] = 1'b1;
    tick();
    vld[k] = 1'b0;
  endtask

  task automatic pop(input int k);
    ack[k] = 1'b1;
    tick();
    ack[k] = 1'b0;
  endtask

  logic [DW-1:0] va [5] = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3, 16'hE4E4};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc, rc, cyc;
    for (int k = 0; k < 2; k++) begin
      din[k] = '0; vld[k] = 0; ovr[k] = 0; clr[k] = 0; ack[k] = 0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_used", 32'(used[0]), 0);
    chk("rst_free_a", 32'(free[0]), 4);
    chk("rst_free_b", 32'(free[1]), 5);
    chk("rst_valid", 32'(ovld[0]), 0);
    chk("rst_stall", 32'(stall[0]), 0);
    chk("rst_flags", 32'({ovf[0], udf[0]}), 0);
    rst_n = 1'b1;
    tick();

    // Fill to full
    for (int i = 0; i < 4; i++) begin
      din[0] = va[i]; vld[0] = 1'b1;
      tick();
      chk("fill_used", 32'(used[0]), 32'(i + 1));
    end
    vld[0] = 1'b0;
    chk("full_stall", 32'(stall[0]), 1);
    chk("full_free", 32'(free[0]), 0);
    chk("full_head", 32'(dout[0]), 32'h0000A0A0);

    // Write while full, no pop: dropped
    push(0, va[4]);
    chk("ovf_pulse", 32'(ovf[0]), 1);
    chk("ovf_used", 32'(used[0]), 4);
    tick();
    chk("ovf_clear", 32'(ovf[0]), 0);
    for (int i = 0; i < 4; i++) begin
      chk("pop_order", 32'(dout[0]), 32'(va[i]));
      pop(0);
    end
    chk("drained", 32'(ovld[0]), 0);

    // Write while full with simultaneous pop: accepted
    for (int i = 0; i < 4; i++) push(0, va[i]);
    din[0] = va[4]; vld[0] = 1'b1; ack[0] = 1'b1;
    tick();
    vld[0] = 1'b0; ack[0] = 1'b0;
    chk("full_rw_ovf", 32'(ovf[0]), 0);
    chk("full_rw_used", 32'(used[0]), 4);
    for (int i = 1; i < 5; i++) begin
      chk("full_rw_order", 32'(dout[0]), 32'(va[i]));
      pop(0);
    end

    // Simultaneous push/pop at occupancy 1
    push(0, va[0]);
    din[0] = va[1]; vld[0] = 1'b1; ack[0] = 1'b1;
    tick();
    vld[0] = 1'b0; ack[0] = 1'b0;
    chk("occ1_used", 32'(used[0]), 1);
    chk("occ1_head", 32'(dout[0]), 32'h0000B1B1);
    pop(0);

    // Pop while empty
    pop(0);
    chk("udf_pulse", 32'(udf[0]), 1);
    chk("udf_used", 32'(used[0]), 0);
    tick();
    chk("udf_clear", 32'(udf[0]), 0);

    // Clear with concurrent write, then clear with pop while empty
    for (int i = 0; i < 3; i++) push(0, va[i]);
    din[0] = va[3]; vld[0] = 1'b1; clr[0] = 1'b1;
    tick();
    vld[0] = 1'b0; clr[0] = 1'b0;
    chk("clr_used", 32'(used[0]), 0);
    chk("clr_valid", 32'(ovld[0]), 0);
    chk("clr_flags", 32'({ovf[0], udf[0]}), 0);
    clr[0] = 1'b1; ack[0] = 1'b1;
    tick();
    clr[0] = 1'b0; ack[0] = 1'b0;
    chk("clr_no_udf", 32'(udf[0]), 0);

    // Async reset in the middle of a burst
    din[0] = va[0]; vld[0] = 1'b1;
    tick();
    din[0] = va[1];
    tick();
    din[0] = va[2];
    #2 rst_n = 1'b0;
    #1;
    chk("arst_used", 32'(used[0]), 0);
    chk("arst_valid", 32'(ovld[0]), 0);
    chk("arst_free", 32'(free[0]), 4);
    vld[0] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    push(0, va[4]);
    chk("post_rst_valid", 32'(ovld[0]), 1);
    chk("post_rst_used", 32'(used[0]), 1);
    chk("post_rst_head", 32'(dout[0]), 32'h0000E4E4);
    pop(0);

    // DEPTH=5, THRESH=2: stall threshold and override
    for (int i = 0; i < 3; i++) push(1, DW'(16'h0100 + i));
    chk("b_stall", 32'(stall[1]), 1);
    chk("b_free", 32'(free[1]), 2);
    ovr[1] = 1'b1;
    #1 chk("b_ovr_on", 32'(stall[1]), 0);
    ovr[1] = 1'b0;
    #1 chk("b_ovr_off", 32'(stall[1]), 1);

    // Streaming through several pointer wraps
    wc = 3; rc = 0; cyc = 0;
    tick();
    while (rc < 15 && cyc < 80) begin
      vld[1] = (wc < 15);
      din[1] = DW'(16'h0100 + wc);
      ack[1] = ovld[1];
      if (ack[1]) begin
        chk("wrap_data", 32'(dout[1]), 32'(16'h0100 + rc));
        rc++;
      end
      if (vld[1]) wc++;
      tick();
      cyc++;
    end
    vld[1] = 1'b0; ack[1] = 1'b0;
    chk("wrap_count", 32'(rc), 15);
    chk("wrap_empty", 32'(used[1]), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cr_kme_fifo_param.md
CR_KME_FIFO_PARAM -- requirements
Module: cr_kme_fifo_param

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 128, giving the payload width in bits.
REQ-002 The block SHALL provide parameter DEPTH, default 4, giving the number of entries (legal 2..256, non-power-of-two allowed).
REQ-003 The block SHALL provide parameter STALL_THRESH, default 0, giving the stall point: stall when free slots <= STALL_THRESH (legal 0..DEPTH-1).
REQ-004 The block SHALL use CW = $clog2(DEPTH+1) as the width of the occupancy ports.
REQ-005 The block SHALL have one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-006 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-007 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-008 Port fifo_in: input, DATA_WIDTH bits, write data.
REQ-009 Port fifo_in_valid: input, 1 bit, write request.
REQ-010 Port fifo_in_stall_override: input, 1 bit, forces fifo_in_stall low.
REQ-011 Port clear: input, 1 bit, synchronous flush.
REQ-012 Port fifo_out_ack: input, 1 bit, consumer pop.
REQ-013 Port fifo_in_stall: output, 1 bit, back-pressure to the producer.
REQ-014 Port fifo_out: output, DATA_WIDTH bits, head entry.
REQ-015 Port fifo_out_valid: output, 1 bit, head entry valid.
REQ-016 Port fifo_overflow: output, 1 bit, one-cycle pulse on a dropped write.
REQ-017 Port fifo_underflow: output, 1 bit, one-cycle pulse on a pop while empty.
REQ-018 Port used_slots: output, CW bits, current occupancy.
REQ-019 Port free_slots: output, CW bits, equal to DEPTH - used_slots.

Function
REQ-020 Ordering SHALL be first-word-fall-through: fifo_out SHALL show the oldest entry whenever fifo_out_valid = 1.
REQ-021 fifo_out_valid SHALL equal (used_slots != 0); ren SHALL be fifo_out_valid & fifo_out_ack.
REQ-022 A write accepted at edge N SHALL raise fifo_out_valid in cycle N+1 when the FIFO was empty; latency is 1 cycle.
REQ-023 A write SHALL be accepted when fifo_in_valid = 1 and either used_slots < DEPTH or ren = 1 in the same cycle.
REQ-024 A write while full with ren = 0 SHALL be dropped, leave all state unchanged, and pulse fifo_overflow the next cycle.
REQ-025 fifo_out_ack = 1 while empty SHALL leave pointers unchanged and pulse fifo_underflow the next cycle.
REQ-026 A simultaneous write and read SHALL keep used_slots constant, including at full (no overflow) and at occupancy 1.
REQ-027 Read and write pointers SHALL wrap from DEPTH-1 to 0 regardless of whether DEPTH is a power of two.
REQ-028 fifo_in_stall SHALL equal (free_slots <= STALL_THRESH) & ~fifo_in_stall_override, combinationally from registered occupancy.
REQ-029 Stall SHALL be advisory only: writes issued while stalled SHALL still obey REQ-023/REQ-024.
REQ-030 When clear = 1, the next edge SHALL set both pointers and used_slots to 0; any write or read in that cycle is discarded and no overflow or underflow pulse is generated.
REQ-031 used_slots and free_slots SHALL be registered and SHALL never exceed DEPTH.

Reset
REQ-032 While rst_n = 0: pointers = 0, used_slots = 0, free_slots = DEPTH, fifo_out_valid = 0, fifo_overflow = 0, fifo_underflow = 0; fifo_in_stall = (DEPTH <= STALL_THRESH) & ~override, i.e. 0 for legal parameters.
REQ-033 Storage contents SHALL NOT be reset; fifo_out is don't-care while fifo_out_valid = 0.
REQ-034 Reset asserted mid-operation SHALL empty the FIFO asynchronously; the first write after deassertion SHALL behave as on an empty FIFO.

Verification
REQ-035 DEPTH=4, THRESH=0: write A,B,C,D on consecutive cycles with no ack -> used_slots 1,2,3,4; fifo_in_stall = 1 after D; fifo_out = A.
REQ-036 Full, then fifo_in_valid=1 with ack=0 -> fifo_overflow pulses 1 cycle; used_slots stays 4; pops return A,B,C,D.
REQ-037 Full, then fifo_in_valid=1 with ack=1 -> no overflow; used_slots = 4; E is returned after D.
REQ-038 Empty, then fifo_out_ack=1 -> fifo_underflow pulses 1 cycle; used_slots stays 0.
REQ-039 DEPTH=5, THRESH=2: push 3, then toggle the override -> stall follows ~override; push/pop 12 entries -> in-order data across pointer wrap.
REQ-040 3 entries held, clear=1 with a simultaneous write -> next cycle used_slots=0, fifo_out_valid=0, no flags; repeat using async rst_n mid-burst -> same result.
